dup_range_n: RTL and testbench
==============================

Name: dup_range_n

Overview:
- Parametrised successor to the fixed two-copy range duplicator generator.
- Internally walks the integer range base, base+step, ... up to (excluding) limit.
- Emits each element `repeat` consecutive times over the codebase's ready/valid generator protocol.
- Sits wherever generated-function modules consume a range stream; width and repeat count are generalised, with negative-step, overflow-safe termination and a last-output flag added.

Parameters:
- WIDTH, 32, signed width of base/limit/step/_0.
- RW, 4, width of the runtime repeat input (max repeat count 2^RW-1).

Ports:
- _clock  input  1  rising-edge clock.
- _reset  input  1  asynchronous, active-low reset; low forces idle/done.
- _start  input  1  high for one cycle: capture inputs in the same cycle and begin generating.
- base  input  WIDTH  signed first value.
- limit  input  WIDTH  signed exclusive bound.
- step  input  WIDTH  signed increment.
- repeat  input  RW  unsigned copies per element.
- _ready  input  1  consumer ready for output.
- _valid  output  1  _0/_last hold a valid output.
- _done  output  1  high when the module has finished (or is idle after reset).
- _0  output  WIDTH  signed output value.
- _last  output  1  qualifies _valid: this is the final output of the sequence.

Behaviour:
- Reset (_reset low, async): _valid=0, _done=1, _0=0, _last=0, state=DONE, internal counters cleared.
- Transfer occurs on a rising edge with _valid && _ready. _0/_last are held stable while _valid && !_ready.
- States:
  - DONE: _done=1, _valid=0.
  - EMIT: _done=0.
- _start (sampled only while _reset high) in any state, including mid-sequence:
  - Latch base/limit/step/repeat; cur=base, copy=0.
  - Abandon any pending output: _valid<=0 in that edge.
  - If step==0, repeat==0, or base is outside the range (step>0 && base>=limit, or step<0 && base<=limit): go to DONE. _done is low for exactly the cycle after _start, then high; no _valid ever asserted.
  - Otherwise go to EMIT.
- EMIT, when !_valid or a transfer occurs this edge:
  - Present _0<=cur, _valid<=1. Then copy++.
  - When copy reaches repeat: copy=0, cur=cur+step.
- Range termination:
  - cur+step is computed in WIDTH+1 signed bits.
  - The range ends if the sum overflows WIDTH, or if step>0 && sum>=limit, or if step<0 && sum<=limit.
- _last=1 on the output that is the final copy of the final element; 0 otherwise.
- After the transfer of the _last output: _valid<=0, state=DONE, _done=1 in the next cycle.
- Latency: first _valid one cycle after _start.
- Throughput: with _ready held high, one output per cycle with no bubbles, including across element boundaries.
- Simultaneous _start and transfer: _start wins; the transfer is consumed but no further output from the old sequence appears.
- _ready while DONE is ignored. _done never asserts concurrently with _valid.

Test Plan:
- WIDTH=32, _start with (0,10,2,repeat=2), _ready=1 → _0 sequence 0,0,2,2,4,4,6,6,8,8 on consecutive cycles. _last only on the second 8. _done=1 the cycle after.
- Same stimulus, _ready toggled 1,0,0,1,... → identical sequence, no duplicates or drops; _0 stable while stalled.
- (10,0,-3,repeat=3) → 10,10,10,7,7,7,4,4,4,1,1,1, _last on the final 1.
- step=0, or repeat=0, or (5,5,1,repeat=2) → no _valid ever. _done low for one cycle after _start, then high.
- WIDTH=8, (100,127,100,repeat=1) → single output 100 with _last=1; no wrapped -56 emitted.
- Mid-sequence events on (0,10,2,repeat=2):
  - After 3 transfers, _start (20,23,1,repeat=1) → next outputs 20,21,22.
  - Separately, drive _reset low mid-stream → _valid=0 and _done=1 immediately (asynchronously).

Source files
------------

// File: rtl/dup_range_n.sv
// Range generator: walks base, base+step, ... (excluding limit) and emits each element
// repeat_count times over a ready/valid handshake, flagging the final output with _last.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_DONE | idle or finished; _done=1, _valid=0
// S_EMIT | producing outputs; a new one is loaded whenever the slot is free
module dup_range_n #(
   parameter int WIDTH = 32,
   parameter int RW    = 4
) (
   input  logic                    _clock,
   input  logic                    _reset,
   input  logic                    _start,
   input  logic signed [WIDTH-1:0] base,
   input  logic signed [WIDTH-1:0] limit,
   input  logic signed [WIDTH-1:0] step,
   input  logic        [RW-1:0]    repeat_count,
   input  logic                    _ready,
   output logic                    _valid,
   output logic                    _done,
   output logic signed [WIDTH-1:0] _0,
   output logic                    _last
);

   typedef enum logic {S_DONE, S_EMIT} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] cur_q;
   logic signed [WIDTH-1:0] lim_q;
   logic signed [WIDTH-1:0] step_q;
   logic        [RW-1:0]    rep_q;
   logic        [RW-1:0]    copy_q;

   logic signed [WIDTH:0]   cur_ext;
   logic signed [WIDTH:0]   step_ext;
   logic signed [WIDTH:0]   lim_ext;
   logic signed [WIDTH:0]   sum;
   logic                    sum_ovf;
   logic                    range_end;
   logic        [RW:0]      copy_inc;
   logic                    final_copy;
   logic                    start_bad;
   logic                    slot_free;

   // One extra bit so cur+step never wraps before the bound test sees it.
   assign cur_ext  = {cur_q[WIDTH-1], cur_q};
   assign step_ext = {step_q[WIDTH-1], step_q};
   assign lim_ext  = {lim_q[WIDTH-1], lim_q};
   assign sum      = cur_ext + step_ext;
   assign sum_ovf  = sum[WIDTH] ^ sum[WIDTH-1];

   assign range_end = sum_ovf
                    || (!step_q[WIDTH-1] && (sum >= lim_ext))
                    || ( step_q[WIDTH-1] && (sum <= lim_ext));

   assign copy_inc   = {1'b0, copy_q} + {{RW{1'b0}}, 1'b1};
   assign final_copy = (copy_inc == {1'b0, rep_q});

   assign start_bad = (step == '0) || (repeat_count == '0)
                    || (!step[WIDTH-1] && (base >= limit))
                    || ( step[WIDTH-1] && (base <= limit));

   assign slot_free = !_valid || _ready;

   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         state  <= S_DONE;
         cur_q  <= '0;
         lim_q  <= '0;
         step_q <= '0;
         rep_q  <= '0;
         copy_q <= '0;
         _valid <= 1'b0;
         _done  <= 1'b1;
         _0     <= '0;
         _last  <= 1'b0;
      end else if (_start) begin
         cur_q  <= base;
         lim_q  <= limit;
         step_q <= step;
         rep_q  <= repeat_count;
         copy_q <= '0;
         _valid <= 1'b0;
         _last  <= 1'b0;
         _done  <= 1'b0;
         state  <= start_bad ? S_DONE : S_EMIT;
      end else begin
         case (state)
            S_DONE: begin
               _done  <= 1'b1;
               _valid <= 1'b0;
               _last  <= 1'b0;
            end
            S_EMIT: begin
               if (slot_free) begin
                  if (_valid && _last) begin
                     _valid <= 1'b0;
                     _last  <= 1'b0;
                     _done  <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     _0     <= cur_q;
                     _valid <= 1'b1;
                     _last  <= final_copy && range_end;
                     if (final_copy) begin
                        copy_q <= '0;
                        cur_q  <= sum[WIDTH-1:0];
                     end else begin
                        copy_q <= copy_inc[RW-1:0];
                     end
                  end
               end
            end
            default: state <= S_DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_dup_range_n.sv
// Randomised and directed bench for dup_range_n; an arithmetic range model feeds a
// scoreboard queue that a free-running monitor drains on every handshake.
module tb_dup_range_n;
   localparam int W  = 32;
   localparam int RW = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic signed [W-1:0] base, limit, step;
   logic        [RW-1:0] rep;
   logic                ready;
   logic                valid, done, last;
   logic signed [W-1:0] out;

   always #5 clk = ~clk;

   dup_range_n #(.WIDTH(W), .RW(RW)) dut (
      ._clock(clk), ._reset(rst_n), ._start(start),
      .base(base), .limit(limit), .step(step), .repeat_count(rep),
      ._ready(ready), ._valid(valid), ._done(done), ._0(out), ._last(last)
   );

   typedef struct packed {
      logic signed [W-1:0] v;
      logic                l;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_xfer  = 0;
   int   ready_mode = 0;
   bit   chk_stall = 1'b0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer walk of the range, wide enough that it cannot overflow.
   task automatic model(input longint b, input longint l, input longint s, input int r);
      longint v;
      sb.delete();
      if (s == 0 || r == 0) return;
      v = b;
      while ((s > 0 && v < l) || (s < 0 && v > l)) begin
         for (int k = 0; k < r; k++) begin
            exp_t e;
            e.v = v[W-1:0];
            e.l = 1'b0;
            sb.push_back(e);
         end
         v = v + s;
      end
      if (sb.size() > 0) sb[sb.size()-1].l = 1'b1;
   endtask

   // Ready pattern generator: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random.
   initial begin
      int idx = 0;
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               ready = (idx % 4 == 0) || (idx % 4 == 3);
               idx++;
            end
            2: ready = 1'($urandom_range(0, 1));
            default: ready = 1'b1;
         endcase
      end
   end

   // Monitor: drains the scoreboard on each handshake.
   logic                prev_stall = 1'b0;
   logic signed [W-1:0] prev_v;
   logic                prev_l;
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("valid_done_exclusive", valid && done, 0);
         if (chk_stall && prev_stall) begin
            check("stall_valid_held", valid, 1);
            check("stall_value_held", out, prev_v);
            check("stall_last_held", last, prev_l);
         end
         if (valid && ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got %0d expected none at %0t", out, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_value", out, e.v);
               check("out_last", last, e.l);
            end
         end
         prev_stall = valid && !ready;
         prev_v     = out;
         prev_l     = last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Start is sampled at one edge; the model replaces the queue right after it.
   task automatic do_start(input longint b, input longint l, input longint s, input int r);
      @(posedge clk);
      #1;
      base  = b[W-1:0];
      limit = l[W-1:0];
      step  = s[W-1:0];
      rep   = r[RW-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      model(b, l, s, r);
   endtask

   task automatic wait_finish(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (done) break;
      end
      check({name, "_finished_in_budget"}, i < budget, 1);
      check({name, "_queue_drained"}, sb.size(), 0);
      check({name, "_valid_low_when_done"}, valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      base  = '0;
      limit = '0;
      step  = '0;
      rep   = '0;
      #12;
      check("reset_valid", valid, 0);
      check("reset_done", done, 1);
      check("reset_out", out, 0);
      check("reset_last", last, 0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Basic run with latency check; ready held high.
      ready_mode = 0;
      do_start(0, 10, 2, 2);
      check("lat_valid_low_after_start", valid, 0);
      check("lat_done_low_after_start", done, 0);
      @(posedge clk);
      #2;
      check("lat_first_valid", valid, 1);
      check("lat_first_value", out, 0);
      wait_finish("basic", 40);

      // Same sequence under back-pressure.
      ready_mode = 1;
      chk_stall  = 1'b1;
      do_start(0, 10, 2, 2);
      wait_finish("stall", 80);
      chk_stall  = 1'b0;

      // Negative step.
      ready_mode = 0;
      do_start(10, 0, -3, 3);
      wait_finish("neg_step", 40);

      // Degenerate parameters: never valid, done low for one cycle only.
      for (int t = 0; t < 3; t++) begin
         case (t)
            0: do_start(0, 10, 0, 2);
            1: do_start(0, 10, 2, 0);
            default: do_start(5, 5, 1, 2);
         endcase
         check("empty_done_low", done, 0);
         check("empty_valid_low", valid, 0);
         @(posedge clk);
         #1;
         check("empty_done_high", done, 1);
         for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("empty_no_valid", valid, 0);
         end
      end

      // Overflow-safe termination in both directions.
      do_start(64'sh7FFF_FF00, 64'sh7FFF_FFFF, 64'sh100, 1);
      wait_finish("ovf_pos", 20);
      do_start(-64'sh8000_0000 + 64'sh50, -64'sh8000_0000, -64'sh100, 2);
      wait_finish("ovf_neg", 20);

      // Restart after three transfers.
      do_start(0, 10, 2, 2);
      n_xfer = 0;
      for (int i = 0; i < 50 && n_xfer < 3; i++) begin
         @(posedge clk);
         #2;
      end
      check("mid_three_transfers", n_xfer >= 3, 1);
      do_start(20, 23, 1, 1);
      wait_finish("mid_restart", 40);

      // Asynchronous reset mid-stream.
      do_start(0, 10, 2, 2);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", valid, 0);
      check("async_rst_done", done, 1);
      check("async_rst_out", out, 0);
      check("async_rst_last", last, 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_done", done, 1);
      check("post_rst_valid", valid, 0);

      // Random sequences under random back-pressure.
      ready_mode = 2;
      for (int i = 0; i < 25; i++) begin
         longint b, l, s;
         int r;
         b = longint'($urandom_range(0, 100)) - 50;
         l = longint'($urandom_range(0, 120)) - 60;
         s = longint'($urandom_range(0, 14)) - 7;
         r = int'($urandom_range(0, 4));
         do_start(b, l, s, r);
         wait_finish("rand", 2000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
